// File: rtl/psum_defs.sv
// Shared definitions for the partial-sum path: default psum width and the
// merge FSM state encoding. Also consumed by the FIFO write-side producer.
package psum_defs;

  localparam int SUM_BW = 23;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    DRAIN = ST_DRAIN
  } state_e;

endpackage

// File: rtl/psum_merge.sv
// Read-side merge of remote partial sums (from the async FIFO) with local
// partial sums. One vector of `len` elements per start pulse; each merged
// sum is presented on a registered valid/ready output.
//
// Handshakes: a word moves on an interface in any cycle where its valid and
// ready are both 1 at the rising clock edge. Valid, once raised, is held with
// stable data until accepted. On the input side the FIFO pop (fifo_rd) and the
// local accept (loc_ready) are the same strobe: both sources are consumed in
// the same cycle or neither is.
module psum_merge
  import psum_defs::*;
#(
  parameter int sum_bw = SUM_BW,
  parameter int len    = 8,
  parameter int cnt_bw = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [sum_bw-1:0] fifo_out,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  input  logic [sum_bw-1:0] loc_in,
  input  logic              loc_valid,
  output logic              loc_ready,
  output logic [sum_bw:0]   out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [cnt_bw-1:0] LAST_IDX = cnt_bw'(len - 1);

  state_e            state_q, state_d;
  logic [cnt_bw-1:0] cnt_q, cnt_d;
  logic [sum_bw:0]   out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              done_q, done_d;

  logic              fire;
  logic              out_accept;
  logic [sum_bw:0]   merged_sum;

  // Pop/accept strobe: both sources present, output slot free or draining
  // this cycle, and never while reset is held.
  always_comb begin
    out_accept = out_valid_q && out_ready;
    fire       = (state_q == RUN) && !fifo_empty && loc_valid &&
                 (!out_valid_q || out_ready) && !reset;
    merged_sum = {fifo_out[sum_bw-1], fifo_out} + {loc_in[sum_bw-1], loc_in};
  end

  // Next-state, element counter, output register and done pulse.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (fire) begin
          cnt_d = cnt_q + cnt_bw'(1);
          if (cnt_q == LAST_IDX) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_accept) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A fire reloads the slot even when the old word leaves this same cycle.
    if (fire) begin
      out_data_d  = merged_sum;
      out_valid_d = 1'b1;
    end else if (out_accept) begin
      out_valid_d = 1'b0;
    end
  end

  // Registers with synchronous reset; a reset mid-vector simply aborts.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign fifo_rd   = fire;
  assign loc_ready = fire;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule
